ram_test_seq: RTL and testbench
===============================

RAM_TEST_SEQ -- requirements
Module: ram_test_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, RAM address width (16 words).
REQ-002 The block SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to run one write/readback test; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first RAM address of the test window; sampled with start.
REQ-007 len  input  ADDR_W  word count minus one (0 -> 1 word, 15 -> 16 words); sampled with start.
REQ-008 seed  input  DATA_W  pattern seed; sampled with start.
REQ-009 ram_we  output  1  write enable to downstream RAM.
REQ-010 ram_re  output  1  read enable to downstream RAM.
REQ-011 ram_addr  output  ADDR_W  RAM address.
REQ-012 ram_din  output  DATA_W  RAM write data.
REQ-013 ram_dout  input  DATA_W  RAM read data, valid the cycle after the edge that samples ram_re=1.
REQ-014 busy  output  1  high while a test is in progress.
REQ-015 done  output  1  one-cycle pulse at test completion.
REQ-016 pass  output  1  high when the last completed test had zero mismatches.
REQ-017 err_count  output  ADDR_W+1  mismatch count of the current or last test (0..16).
REQ-018 first_err_addr  output  ADDR_W  RAM address of the first mismatch; 0 when none.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 The FSM SHALL have states IDLE, WRITE, READ, DRAIN.
REQ-021 IDLE with start=1 SHALL: latch base_addr/len/seed, clear err_count, pass and first_err_addr, and enter WRITE; start outside IDLE SHALL be ignored.
REQ-022 Word i (0..len) SHALL use address (base_addr+i) mod 2^ADDR_W (wrap-around) and data (seed+i) mod 2^DATA_W.
REQ-023 WRITE SHALL assert ram_we=1, ram_re=0 for len+1 consecutive cycles, one word per cycle in ascending i, then enter READ.
REQ-024 READ SHALL assert ram_re=1, ram_we=0 for len+1 consecutive cycles, same address order, then enter DRAIN.
REQ-025 ram_we and ram_re SHALL never be high together and SHALL be 0 in IDLE and DRAIN; ram_din SHALL be 0 when ram_we=0.
REQ-026 The expected value SHALL be pipelined one cycle; the cycle after each read, ram_dout SHALL be compared with the expected value for that address.
REQ-027 Each mismatch SHALL increment err_count; on the first mismatch, first_err_addr SHALL capture that address.
REQ-028 DRAIN SHALL last one cycle, covering the compare for the final read, then return to IDLE.
REQ-029 busy SHALL be 1 exactly in WRITE, READ and DRAIN: 2*(len+1)+1 cycles per test.
REQ-030 done SHALL pulse 1 for the first IDLE cycle after DRAIN, with pass = (err_count==0) updated in that same cycle.
REQ-031 pass, err_count and first_err_addr SHALL hold until the next accepted start.
REQ-032 A start asserted during the done cycle SHALL be accepted.

Reset
REQ-033 rst=1 at an edge SHALL force IDLE, ram_we=0, ram_re=0, ram_addr=0, ram_din=0, busy=0, done=0, pass=0, err_count=0 and first_err_addr=0 on the next cycle, in any state.
REQ-034 rst SHALL take priority over start.
REQ-035 Reset mid-test SHALL produce no done pulse, and no partial write SHALL continue after the reset edge.

Verification
REQ-036 base=1, len=2, seed=AA -> writes AA@1, AB@2, AC@3; reads 1,2,3; busy 7 cycles; done pulse; pass=1; err_count=0.
REQ-037 Wrap case, base=E, len=3, seed=FE -> writes FE@E, FF@F, 00@0, 01@1; reads same order; pass=1.
REQ-038 RAM model flips bit 0 on a read of addr 2 (base=0, len=3, seed=10) -> err_count=1, first_err_addr=2, pass=0.
REQ-039 len=F, base=0 -> 16 writes, 16 reads, busy 33 cycles; extra start pulses while busy are ignored (exactly one done).
REQ-040 rst on the 2nd WRITE cycle -> next cycle ram_we=0, busy=0, no done; a following start with base=5, len=0, seed=33 passes.

Source files
------------

// File: rtl/ram_test_seq.sv
// ram_test_seq: writes a seed-derived pattern (seed+i) over a wrapping RAM window, reads it back and counts mismatches.
// Latency: 2*(len+1)+1 busy cycles per test; done pulses in the first idle cycle after, with pass/err_count valid there.
// Backpressure: none; start is taken only while idle (including the done cycle) and ignored while busy.
// Ports: clk/rst (sync, active-high); start/base_addr/len/seed request a test;
//        ram_we/ram_re/ram_addr/ram_din drive the RAM, ram_dout returns read data one cycle after a read;
//        busy/done/pass/err_count/first_err_addr report progress and result.
module ram_test_seq #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] seed,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    localparam logic [ADDR_W:0] ERR_ONE = (ADDR_W+1)'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt, idx_inc;
    logic [ADDR_W-1:0] base_q, len_q;
    logic [DATA_W-1:0] seed_q;
    logic              last;

    // Next values of the registered RAM-side outputs.
    logic              we_nxt, re_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] din_nxt;

    // Compare pipeline: expected data/address of the read issued last cycle.
    logic              cmp_vld;
    logic [DATA_W-1:0] exp_dat;
    logic [ADDR_W-1:0] exp_addr;
    logic              mismatch;

    assign idx_inc  = idx + ADDR_W'(1);
    assign last     = (idx == len_q);
    assign mismatch = cmp_vld && (ram_dout != exp_dat);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // idx is the word index of the access being presented in the current cycle,
    // so outputs for word idx+1 are computed here and registered at the edge.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        we_nxt    = 1'b0;
        re_nxt    = 1'b0;
        addr_nxt  = '0;
        din_nxt   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WRITE;
                    idx_nxt   = '0;
                    we_nxt    = 1'b1;
                    addr_nxt  = base_addr;
                    din_nxt   = seed;
                end
            end
            WRITE: begin
                if (last) begin
                    state_nxt = READ;
                    idx_nxt   = '0;
                    re_nxt    = 1'b1;
                    addr_nxt  = base_q;
                end else begin
                    idx_nxt  = idx_inc;
                    we_nxt   = 1'b1;
                    addr_nxt = base_q + idx_inc;
                    din_nxt  = seed_q + DATA_W'(idx_inc);
                end
            end
            READ: begin
                if (last) begin
                    state_nxt = DRAIN;
                end else begin
                    idx_nxt  = idx_inc;
                    re_nxt   = 1'b1;
                    addr_nxt = base_q + idx_inc;
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            base_q         <= '0;
            len_q          <= '0;
            seed_q         <= '0;
            ram_we         <= 1'b0;
            ram_re         <= 1'b0;
            ram_addr       <= '0;
            ram_din        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            cmp_vld        <= 1'b0;
            exp_dat        <= '0;
            exp_addr       <= '0;
        end else begin
            idx      <= idx_nxt;
            ram_we   <= we_nxt;
            ram_re   <= re_nxt;
            ram_addr <= addr_nxt;
            ram_din  <= din_nxt;
            busy     <= (state_nxt != IDLE);
            done     <= (state == DRAIN);

            // Read data arrives the cycle after the read, so the expectation
            // for the address presented now is held one cycle.
            cmp_vld  <= (state == READ);
            exp_dat  <= seed_q + DATA_W'(idx);
            exp_addr <= ram_addr;

            if (mismatch) begin
                err_count <= err_count + ERR_ONE;
                if (err_count == '0) begin
                    first_err_addr <= exp_addr;
                end
            end

            // DRAIN carries the final compare, so fold it into pass directly.
            if (state == DRAIN) begin
                pass <= (err_count == '0) && !mismatch;
            end

            if (state == IDLE && start) begin
                base_q         <= base_addr;
                len_q          <= len;
                seed_q         <= seed;
                err_count      <= '0;
                pass           <= 1'b0;
                first_err_addr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_test_seq.sv
// tb_ram_test_seq: directed tests of ram_test_seq against a cycle-indexed behavioural model and a bench RAM.
// Latency: n/a (bench). Backpressure: n/a.
// The RAM model can flip bit 0 on reads of address 2 to inject a mismatch.
module tb_ram_test_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] base_addr = '0;
    logic [3:0] len = '0;
    logic [7:0] seed = '0;
    logic       ram_we, ram_re;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [3:0] first_err_addr;

    always #5 clk = ~clk;

    ram_test_seq #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .len            (len),
        .seed           (seed),
        .ram_we         (ram_we),
        .ram_re         (ram_re),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- RAM model ----------------
    logic [7:0] mem [16];
    logic       fault = 1'b0;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_addr] ^ ((fault && ram_addr == 4'd2) ? 8'h01 : 8'h00);
    end

    // ---------------- logs / counters ----------------
    int wlog[$];
    int rlog[$];
    int busy_cyc = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (ram_we) wlog.push_back(int'({ram_addr, ram_din}));
        if (ram_re) rlog.push_back(int'(ram_addr));
        if (busy) busy_cyc++;
        if (done) done_cnt++;
    end

    // ---------------- behavioural model ----------------
    // m_t counts cycles since the accepting edge: 1..N writes, N+1..2N reads,
    // 2N+1 the drain cycle; the next cycle is the done cycle.
    bit m_on = 0, m_act = 0, m_done = 0, m_pass = 0;
    int m_t = 0, m_n = 0, m_base = 0, m_seed = 0;
    int m_err = 0, m_first = 0, m_xerr = 0, m_xfirst = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1; m_act = 0; m_done = 0; m_pass = 0;
            m_err = 0; m_first = 0; m_t = 0;
        end else begin
            m_done = 0;
            if (m_act) begin
                if (m_t == 2 * m_n + 1) begin
                    m_act = 0; m_done = 1;
                    m_err = m_xerr; m_first = m_xfirst; m_pass = (m_xerr == 0);
                end else begin
                    m_t++;
                end
            end else if (start) begin
                m_act = 1; m_t = 1; m_n = int'(len) + 1;
                m_base = int'(base_addr); m_seed = int'(seed);
                m_err = 0; m_first = 0; m_pass = 0;
                // A faulty read happens only if address 2 lies inside the window.
                m_xerr = (fault && (((2 - m_base) & 15) < m_n)) ? 1 : 0;
                m_xfirst = (m_xerr != 0) ? 2 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("busy", busy, int'(m_act));
            chk("done", done, int'(m_done));
            if (m_act && m_t <= m_n) begin
                chk("wr_we", ram_we, 1);
                chk("wr_re", ram_re, 0);
                chk("wr_addr", ram_addr, (m_base + m_t - 1) % 16);
                chk("wr_data", ram_din, (m_seed + m_t - 1) % 256);
                chk("err_cleared", err_count, 0);
                chk("pass_cleared", pass, 0);
                chk("first_cleared", first_err_addr, 0);
            end else if (m_act && m_t <= 2 * m_n) begin
                chk("rd_we", ram_we, 0);
                chk("rd_re", ram_re, 1);
                chk("rd_addr", ram_addr, (m_base + m_t - m_n - 1) % 16);
                chk("rd_din_zero", ram_din, 0);
            end else begin
                chk("idle_we", ram_we, 0);
                chk("idle_re", ram_re, 0);
                chk("idle_din", ram_din, 0);
                if (!m_act) begin
                    chk("pass", pass, int'(m_pass));
                    chk("err_count", err_count, m_err);
                    chk("first_err_addr", first_err_addr, m_first);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Pulses start for one edge and returns in the done cycle.
    task automatic run_test(input logic [3:0] b, input logic [3:0] l, input logic [7:0] s,
                            input string nm, input int exp_busy);
        int k = 0;
        busy_cyc  = 0;
        done_cnt  = 0;
        base_addr = b;
        len       = l;
        seed      = s;
        start     = 1'b1;
        tick();
        start = 1'b0;
        while (!done && k < 100) begin
            tick();
            k++;
        end
        chk({nm, "_done_seen"}, int'(done), 1);
        chk({nm, "_busy_cycles"}, busy_cyc, exp_busy);
    endtask

    int t1_w[3] = '{'h1AA, 'h2AB, 'h3AC};
    int t1_r[3] = '{1, 2, 3};

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_we", ram_we, 0);
        chk("rst_re", ram_re, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_first", first_err_addr, 0);
        rst = 1'b0;
        tick();
        tick();

        // Basic window
        wlog.delete();
        rlog.delete();
        run_test(4'h1, 4'h2, 8'hAA, "t1", 7);
        chk("t1_nwrites", wlog.size(), 3);
        chk("t1_nreads", rlog.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_write_log", (i < wlog.size()) ? wlog[i] : -1, t1_w[i]);
            chk("t1_read_log", (i < rlog.size()) ? rlog[i] : -1, t1_r[i]);
        end
        chk("t1_pass", pass, 1);
        chk("t1_err", err_count, 0);

        // Wrap-around window, started in the done cycle of the previous test
        run_test(4'hE, 4'h3, 8'hFE, "t2", 9);
        chk("t2_mem_e", int'(mem[14]), 'hFE);
        chk("t2_mem_f", int'(mem[15]), 'hFF);
        chk("t2_mem_0", int'(mem[0]), 'h00);
        chk("t2_mem_1", int'(mem[1]), 'h01);
        chk("t2_pass", pass, 1);
        repeat (3) tick();

        // Injected read fault at address 2
        fault = 1'b1;
        run_test(4'h0, 4'h3, 8'h10, "t3", 9);
        chk("t3_err", err_count, 1);
        chk("t3_first", first_err_addr, 2);
        chk("t3_pass", pass, 0);
        repeat (4) tick();
        fault = 1'b0;
        chk("t3_pass_hold", pass, 0);
        chk("t3_err_hold", err_count, 1);

        // Full 16-word window with extra start pulses while busy
        fork
            run_test(4'h0, 4'hF, 8'h5A, "t4", 33);
            begin
                repeat (4) tick();
                base_addr = 4'h9;
                len       = 4'h1;
                seed      = 8'h00;
                start     = 1'b1;
                repeat (3) tick();
                start = 1'b0;
                tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        join
        repeat (4) tick();
        chk("t4_done_count", done_cnt, 1);
        chk("t4_pass", pass, 1);
        chk("t4_mem_f", int'(mem[15]), 'h69);

        // Reset during the second write cycle
        base_addr = 4'h0;
        len       = 4'h3;
        seed      = 8'h20;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t5_we_write2", ram_we, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_we_after_rst", ram_we, 0);
        chk("t5_busy_after_rst", busy, 0);
        chk("t5_done_after_rst", done, 0);
        done_cnt = 0;
        repeat (6) tick();
        chk("t5_no_done", done_cnt, 0);
        chk("t5_mem_0", int'(mem[0]), 'h20);
        chk("t5_mem_1", int'(mem[1]), 'h21);
        chk("t5_mem_2_untouched", int'(mem[2]), 'h5C);

        // Single-word test after the reset
        run_test(4'h5, 4'h0, 8'h33, "t6", 3);
        chk("t6_pass", pass, 1);
        chk("t6_err", err_count, 0);
        chk("t6_mem_5", int'(mem[5]), 'h33);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
